// File: rtl/seq_match_ctrl.sv
// Serial pattern-match controller: loads pattern/length/policy, arms a search over a
// valid-qualified bit stream, counts hits and raises irq on threshold or window timeout.
// Optional: define SEQ_CTRL_AUTO_REARM_EN so irq_ack in DONE re-arms instead of idling.
module seq_match_ctrl #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [WIN_W-1:0] cfg_window,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  output logic [1:0]       irq_status,
  input  logic             irq_ack
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PAT_W-1:0]  pattern_q;
  logic [3:0]        len_q;
  logic              overlap_q;
  logic [CNT_W-1:0]  thresh_q;
  logic [WIN_W-1:0]  window_q;
  logic              cfg_ok_q;

  logic [PAT_W-1:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [WIN_W-1:0]  win_cnt_q;

  logic              cfg_fire, cfg_legal;
  logic [PAT_W-1:0]  len_mask, hist_nxt;
  logic [FILL_W-1:0] fill_inc;
  logic [CNT_W-1:0]  cnt_inc, thresh_eff;
  logic [WIN_W-1:0]  win_inc;
  logic              hit, thr_hit, timeout;
  logic              arm_clear, shift, to_done, ack;

  assign cfg_fire  = cfg_valid && (state_q == S_IDLE);
  assign cfg_legal = (cfg_len != 4'd0) && (32'(cfg_len) <= PAT_W);

  // Evaluate the hit against the history as it will look after this bit shifts in.
  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    hist_nxt   = {hist_q[PAT_W-2:0], sin};
    fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    thresh_eff = (thresh_q == '0) ? CNT_W'(1) : thresh_q;
    win_inc    = win_cnt_q + WIN_W'(1);
    hit        = (32'(fill_inc) >= 32'(len_q)) &&
                 (((hist_nxt ^ pattern_q) & len_mask) == '0);
    thr_hit    = hit && (cnt_inc >= thresh_eff);
    timeout    = (window_q != '0) && (win_inc == window_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    arm_clear = 1'b0;
    shift     = 1'b0;
    to_done   = 1'b0;
    ack       = 1'b0;
    cfg_ready = (state_q == S_IDLE);
    busy      = (state_q == S_ARMED);
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !cfg_valid && cfg_ok_q) begin
            state_d   = S_ARMED;
            arm_clear = 1'b1;
          end
        end
        S_ARMED: begin
          if (sin_valid) begin
            shift = 1'b1;
            if (thr_hit || timeout) begin
              state_d = S_DONE;
              to_done = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (irq_ack) begin
            ack = 1'b1;
`ifdef SEQ_CTRL_AUTO_REARM_EN
            state_d   = S_ARMED;
            arm_clear = 1'b1;
`else
            state_d   = S_IDLE;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q  <= '0;
      len_q      <= '0;
      overlap_q  <= 1'b0;
      thresh_q   <= '0;
      window_q   <= '0;
      cfg_ok_q   <= 1'b0;
      hist_q     <= '0;
      fill_q     <= '0;
      win_cnt_q  <= '0;
      match      <= 1'b0;
      match_cnt  <= '0;
      irq        <= 1'b0;
      irq_status <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && !cfg_legal;
      match   <= 1'b0;
      if (cfg_fire && cfg_legal) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        thresh_q  <= cfg_thresh;
        window_q  <= cfg_window;
        cfg_ok_q  <= 1'b1;
      end
      if (arm_clear) begin
        hist_q    <= '0;
        fill_q    <= '0;
        win_cnt_q <= '0;
        match_cnt <= '0;
      end
      if (shift) begin
        hist_q    <= hist_nxt;
        win_cnt_q <= win_inc;
        if (hit) begin
          match     <= 1'b1;
          match_cnt <= cnt_inc;
          // Non-overlapping mode demands len fresh bits before the next hit.
          fill_q    <= overlap_q ? fill_inc : '0;
        end else begin
          fill_q <= fill_inc;
        end
      end
      if (to_done) begin
        irq        <= 1'b1;
        irq_status <= thr_hit ? 2'b01 : 2'b10;
      end else if (ack || stop) begin
        irq        <= 1'b0;
        irq_status <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_seq_match_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  logic             clk, rst_n;
  logic             cfg_valid, cfg_ready, cfg_overlap, cfg_err;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic [CNT_W-1:0] cfg_thresh;
  logic [WIN_W-1:0] cfg_window;
  logic             start, stop, sin, sin_valid, busy, match, irq, irq_ack;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       irq_status;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit         m_cfg_ok, m_ovl, m_armed, m_done;
  logic [7:0] m_pat;
  int         m_len, m_thr, m_win, m_cnt, m_wcnt;
  int         bits[$];
  bit         exp_match, exp_irq, exp_err;
  int         exp_status;

  seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
    .cfg_window(cfg_window), .cfg_err(cfg_err),
    .start(start), .stop(stop), .sin(sin), .sin_valid(sin_valid),
    .busy(busy), .match(match), .match_cnt(match_cnt),
    .irq(irq), .irq_status(irq_status), .irq_ack(irq_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_thresh = '0; cfg_window = '0; start = 0; stop = 0;
    sin = 0; sin_valid = 0; irq_ack = 0;
  endtask

  task automatic model_reset();
    m_cfg_ok = 0; m_ovl = 0; m_armed = 0; m_done = 0; m_pat = '0;
    m_len = 0; m_thr = 0; m_win = 0; m_cnt = 0; m_wcnt = 0;
    bits.delete();
    exp_match = 0; exp_irq = 0; exp_err = 0; exp_status = 0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_tick();
    bit idle, hit, dthr, dto;
    int thr_eff;
    idle      = !m_armed && !m_done;
    exp_err   = 0;
    exp_match = 0;
    if (idle && cfg_valid) begin
      if (cfg_len >= 1 && int'(cfg_len) <= PAT_W) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        m_thr = int'(cfg_thresh); m_win = int'(cfg_window); m_cfg_ok = 1;
      end else exp_err = 1;
    end
    if (stop) begin
      m_armed = 0; m_done = 0; exp_irq = 0; exp_status = 0;
    end else if (idle) begin
      if (start && !cfg_valid && m_cfg_ok) begin
        m_armed = 1; bits.delete(); m_cnt = 0; m_wcnt = 0;
      end
    end else if (m_armed) begin
      if (sin_valid) begin
        bits.push_back(int'(sin));
        if (bits.size() > PAT_W) void'(bits.pop_front());
        m_wcnt = (m_wcnt + 1) % 65536;
        hit = (bits.size() >= m_len);
        for (int k = 0; k < m_len; k++)
          if (hit && bits[bits.size()-1-k] != int'(m_pat[k])) hit = 0;
        thr_eff = (m_thr == 0) ? 1 : m_thr;
        dthr = 0;
        if (hit) begin
          exp_match = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) bits.delete();
          dthr = (m_cnt >= thr_eff);
        end
        dto = (m_win != 0) && (m_wcnt == m_win);
        if (dthr || dto) begin
          m_armed = 0; m_done = 1; exp_irq = 1; exp_status = dthr ? 1 : 2;
        end
      end
    end else if (irq_ack) begin
      exp_irq = 0; exp_status = 0; m_done = 0;
`ifdef SEQ_CTRL_AUTO_REARM_EN
      m_armed = 1; bits.delete(); m_cnt = 0; m_wcnt = 0;
`endif
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("cfg_ready",  cfg_ready,  32'(!m_armed && !m_done));
    chk("busy",       busy,       32'(m_armed));
    chk("match",      match,      32'(exp_match));
    chk("match_cnt",  match_cnt,  32'(m_cnt));
    chk("irq",        irq,        32'(exp_irq));
    chk("irq_status", irq_status, 32'(exp_status));
    chk("cfg_err",    cfg_err,    32'(exp_err));
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic [7:0] t, input logic [15:0] w);
    clr(); stop = 1; step();
    clr(); cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cfg_thresh = t; cfg_window = w; step();
    clr();
  endtask

  task automatic do_start();
    clr(); start = 1; step(); clr();
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      clr(); sin_valid = 1; sin = v[i]; step();
    end
    clr();
  endtask

  initial begin
    clr();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_cnt",   match_cnt, 0);
    chk("rst_irq",   irq, 0);
    chk("rst_stat",  irq_status, 0);
    rst_n = 1;

    // illegal lengths with no prior config: error pulse, start ignored
    do_cfg(8'h09, 4'd0, 1, 8'd1, 16'd0);
    chk("t4_err0", cfg_err, 1);
    clr(); step();
    chk("t4_err_clr", cfg_err, 0);
    do_cfg(8'h09, 4'd9, 1, 8'd1, 16'd0);
    chk("t4_err9", cfg_err, 1);
    do_start();
    chk("t4_busy", busy, 0);

    // overlapping, threshold 2
    do_cfg(8'h09, 4'd4, 1, 8'd2, 16'd0);
    do_start();
    chk("t1_busy", busy, 1);
    send_bits(16'b1001, 4);
    chk("t1_m1", match, 1);
    send_bits(16'b001, 3);
    chk("t1_m2", match, 1);
    chk("t1_cnt", match_cnt, 2);
    chk("t1_irq", irq, 1);
    chk("t1_stat", irq_status, 1);
    send_bits(16'b1001, 4);
    chk("done_nomatch", match, 0);
    chk("done_irq", irq, 1);
    clr(); irq_ack = 1; step();
    chk("t6_irq", irq, 0);
    chk("t6_stat", irq_status, 0);
`ifdef SEQ_CTRL_AUTO_REARM_EN
    chk("t6_busy", busy, 1);
    chk("t6_cnt", match_cnt, 0);
`else
    chk("t6_busy", busy, 0);
    chk("t6_cnt", match_cnt, 2);
`endif

    // non-overlapping
    do_cfg(8'h09, 4'd4, 0, 8'd2, 16'd0);
    do_start();
    send_bits(16'b1001001, 7);
    chk("t2_cnt", match_cnt, 1);
    chk("t2_irq", irq, 0);
    chk("t2_busy", busy, 1);

    // window timeout
    do_cfg(8'h09, 4'd4, 1, 8'd1, 16'd5);
    do_start();
    send_bits(16'b1111, 4);
    chk("t3_early", irq, 0);
    send_bits(16'b1, 1);
    chk("t3_irq", irq, 1);
    chk("t3_stat", irq_status, 2);
    chk("t3_match", match, 0);

    // hit and timeout on the same bit: hit wins
    do_cfg(8'h01, 4'd1, 1, 8'd1, 16'd3);
    do_start();
    send_bits(16'b001, 3);
    chk("tie_stat", irq_status, 1);

    // sin_valid gaps, then stop mid-stream
    do_cfg(8'h09, 4'd4, 1, 8'd3, 16'd0);
    do_start();
    send_bits(16'b1, 1);
    clr(); sin = 1; step();
    send_bits(16'b0, 1);
    clr(); sin = 1; step();
    send_bits(16'b01, 2);
    chk("t5_gap_match", match, 1);
    repeat (3) begin clr(); sin = 1; step(); end
    chk("t5_hold_cnt", match_cnt, 1);
    clr(); stop = 1; step();
    chk("t5_busy", busy, 0);
    chk("t5_ready", cfg_ready, 1);
    chk("t5_cnt", match_cnt, 1);

    // asynchronous reset mid-operation; start afterwards needs a new config
    do_start();
    send_bits(16'b10, 2);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt", match_cnt, 0);
    chk("arst_ready", cfg_ready, 1);
    model_reset();
    #1 rst_n = 1;
    do_start();
    chk("arst_start", busy, 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      clr();
      cfg_valid   = ($urandom_range(0, 24) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 10) % 5 == 0 ? $urandom_range(0, 10) : $urandom_range(1, 3));
      cfg_overlap = 1'($urandom_range(0, 1));
      cfg_thresh  = 8'($urandom_range(0, 4));
      cfg_window  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 79) == 0);
      sin_valid   = ($urandom_range(0, 3) != 0);
      sin         = 1'($urandom_range(0, 1));
      irq_ack     = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
